// File: rtl/mips_iter_muldiv.sv
// mips_iter_muldiv: multi-cycle multiply/divide unit for the EX stage.
// Shift-add multiplier (2*WIDTH-bit product) and restoring divider, with
// signed/unsigned modes. Signed operands are reduced to magnitudes on accept
// and the sign is restored in the FINISH state.
// Optional build macro: MULDIV_EARLY_TERM_EN -- when defined, MUL/MULH leave
// CALC as soon as the remaining multiplier bits are all zero.
module mips_iter_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div0
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MULH = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_REM  = 2'd3;

    // Architectural state
    logic [1:0]         state_q,   state_d;
    logic [1:0]         op_q,      op_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    // mul: shifting multiplicand; div: dividend shifting out / quotient in (low half)
    logic [2*WIDTH-1:0] mcand_q,   mcand_d;
    // mul: multiplier shifting right; div: divisor (held)
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    // mul: product accumulator; div: partial remainder (low half)
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic               neg_res_q, neg_res_d;   // negate product / quotient
    logic               neg_rem_q, neg_rem_d;   // negate remainder (sign of a)
    logic               bzero_q,   bzero_d;     // divisor was zero for this op
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [WIDTH-1:0]   result_q,  result_d;
    logic               div0_q,    div0_d;

    // Datapath helpers
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     trial;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic               is_div;
    logic               last_iter;

    // Operand magnitudes, one restoring-divide step and final sign correction
    always_comb begin
        abs_a     = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
        abs_b     = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
        // Remainder stays below the divisor, so trial < 2*divisor and the
        // W-bit subtraction below never loses information when q_bit=1.
        trial     = {acc_q[WIDTH-1:0], mcand_q[WIDTH-1]};
        q_bit     = (trial >= {1'b0, mplier_q});
        rem_sub   = trial[WIDTH-1:0] - mplier_q;
        prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        // Divide by zero forces an all-ones quotient regardless of sign.
        quot_fix  = bzero_q ? {WIDTH{1'b1}}
                  : (neg_res_q ? (~mcand_q[WIDTH-1:0] + 1'b1) : mcand_q[WIDTH-1:0]);
        // For b=0 the remainder equals |a|; re-applying a's sign yields a.
        rem_fix   = neg_rem_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        is_div    = op_q[1];
        last_iter = (cnt_q == CNT_W'(1));
    end

    // Next-state logic for the IDLE -> CALC -> FINISH sequencer and datapath
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        div0_d    = div0_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CALC;
                    op_d      = op;
                    cnt_d     = CNT_W'(WIDTH);
                    mcand_d   = {{WIDTH{1'b0}}, abs_a};
                    mplier_d  = abs_b;
                    acc_d     = '0;
                    neg_res_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = sgn & a[WIDTH-1];
                    bzero_d   = (b == '0);
                    busy_d    = 1'b1;
                end
            end
            S_CALC: begin
`ifdef MULDIV_EARLY_TERM_EN
                if (!is_div && (mplier_q == '0)) begin
                    // No multiplier bits left: the product is already final.
                    state_d = S_FINISH;
                end else
`endif
                begin
                    if (is_div) begin
                        acc_d   = {{WIDTH{1'b0}}, (q_bit ? rem_sub : trial[WIDTH-1:0])};
                        mcand_d = {{WIDTH{1'b0}}, mcand_q[WIDTH-2:0], q_bit};
                    end else begin
                        if (mplier_q[0]) begin
                            acc_d = acc_q + mcand_q;
                        end
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (last_iter) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                case (op_q)
                    OP_MUL:  result_d = prod_fix[WIDTH-1:0];
                    OP_MULH: result_d = prod_fix[2*WIDTH-1:WIDTH];
                    OP_DIV:  result_d = quot_fix;
                    OP_REM:  result_d = rem_fix;
                    default: result_d = prod_fix[WIDTH-1:0];
                endcase
                div0_d = is_div & bzero_q;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            div0_q    <= div0_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign div0   = div0_q;

endmodule

// File: tb/tb_mips_iter_muldiv.sv
// Directed testbench for mips_iter_muldiv: a WIDTH=32 and a WIDTH=8 instance.
module tb_mips_iter_muldiv;

`ifdef MULDIV_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    logic        start = 1'b0, sgn = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0, b = '0, result;
    logic        busy, done, div0;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [1:0]  op8 = 2'd0;
    logic [7:0]  a8 = '0, b8 = '0, result8;
    logic        busy8, done8, div08;

    int passed = 0;
    int total  = 0;

    mips_iter_muldiv #(.WIDTH(32)) dut32 (
        .clk1(clk1), .rst_n(rst_n), .start(start), .op(op), .sgn(sgn),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .div0(div0)
    );

    mips_iter_muldiv #(.WIDTH(8)) dut8 (
        .clk1(clk1), .rst_n(rst_n), .start(start8), .op(op8), .sgn(sgn8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(result8), .div0(div08)
    );

    // Issue one 32-bit operation; optionally pulse start mid-operation with other operands.
    task automatic do_op(input logic [1:0] o, input logic s, input logic [31:0] x, input logic [31:0] y,
                         input bit poke, output logic [31:0] res, output logic d0,
                         output int lat, output int bcnt, output logic dprev);
        @(negedge clk1);
        start = 1'b1; op = o; sgn = s; a = x; b = y;
        @(posedge clk1); #1;
        start = 1'b0;
        dprev = done;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        while (lat < 100) begin
            @(posedge clk1); #1;
            lat++;
            start = 1'b0;
            if (done) break;
            if (busy) bcnt++;
            if (poke && lat == 5) begin
                start = 1'b1; op = 2'd0; sgn = 1'b0; a = 32'd123; b = 32'd7;
            end
        end
        res = result;
        d0  = div0;
        $display("op32 op=%0d sgn=%0d a=%h b=%h -> result=%h div0=%0d latency=%0d", o, s, x, y, res, d0, lat);
    endtask

    task automatic do_op8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                          output logic [7:0] res, output int lat);
        @(negedge clk1);
        start8 = 1'b1; op8 = o; sgn8 = 1'b0; a8 = x; b8 = y;
        @(posedge clk1); #1;
        start8 = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk1); #1;
            lat++;
            if (done8) break;
        end
        res = result8;
        $display("op8 op=%0d a=%h b=%h -> result=%h latency=%0d", o, x, y, res, lat);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk1);
        #1;
        total++; if ({busy, done, div0} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {busy, done, div0}); else passed++;
        total++; if (result !== 32'd0) $display("FAIL reset_result got=%h want=0", result); else passed++;
        total++; if ({busy8, done8, div08} !== 3'b000) $display("FAIL reset8_flags got=%b want=000", {busy8, done8, div08}); else passed++;
        total++; if (result8 !== 8'd0) $display("FAIL reset8_result got=%h want=0", result8); else passed++;
        @(negedge clk1); rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] r; logic d; int lat, bc; logic dp;
        do_op(2'd0, 1'b0, 32'd5040, 32'd8, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'd40320) $display("FAIL mul_result got=%0d want=40320", r); else passed++;
        total++; if (lat !== (ET ? 6 : 33)) $display("FAIL mul_latency got=%0d want=%0d", lat, ET ? 6 : 33); else passed++;
        total++; if (bc !== (ET ? 6 : 33)) $display("FAIL mul_busy_cycles got=%0d want=%0d", bc, ET ? 6 : 33); else passed++;
        total++; if (d !== 1'b0) $display("FAIL mul_div0 got=%b want=0", d); else passed++;
        @(posedge clk1); #1;
        total++; if (done !== 1'b0) $display("FAIL done_one_cycle got=%b want=0", done); else passed++;
    endtask

    task automatic test_signed_mul();
        logic [31:0] r; logic d; int lat, bc; logic dp;
        do_op(2'd1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'h0) $display("FAIL mulh_m1m1 got=%h want=00000000", r); else passed++;
        do_op(2'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'h1) $display("FAIL mul_m1m1 got=%h want=00000001", r); else passed++;
        total++; if (dp !== 1'b0) $display("FAIL back_to_back_done got=%b want=0", dp); else passed++;
        do_op(2'd0, 1'b1, 32'hFFFFFFFD, 32'd5, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'hFFFFFFF1) $display("FAIL mul_m3x5 got=%h want=fffffff1", r); else passed++;
        do_op(2'd1, 1'b1, 32'hFFFFFFFD, 32'd5, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'hFFFFFFFF) $display("FAIL mulh_m3x5 got=%h want=ffffffff", r); else passed++;
        do_op(2'd1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'hFFFFFFFE) $display("FAIL mulhu_max got=%h want=fffffffe", r); else passed++;
    endtask

    task automatic test_divide();
        logic [31:0] r; logic d; int lat, bc; logic dp;
        do_op(2'd2, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'hFFFFFFFD) $display("FAIL div_m7_2 got=%h want=fffffffd", r); else passed++;
        do_op(2'd3, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'hFFFFFFFF) $display("FAIL rem_m7_2 got=%h want=ffffffff", r); else passed++;
        do_op(2'd2, 1'b0, 32'd100, 32'd7, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'd14) $display("FAIL divu_100_7 got=%0d want=14", r); else passed++;
        total++; if (lat !== 33) $display("FAIL div_latency got=%0d want=33", lat); else passed++;
        do_op(2'd3, 1'b0, 32'd100, 32'd7, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'd2) $display("FAIL remu_100_7 got=%0d want=2", r); else passed++;
        do_op(2'd2, 1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'hFFFFFFFD) $display("FAIL div_7_m2 got=%h want=fffffffd", r); else passed++;
        do_op(2'd3, 1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'd1) $display("FAIL rem_7_m2 got=%h want=00000001", r); else passed++;
    endtask

    task automatic test_div_zero();
        logic [31:0] r; logic d; int lat, bc; logic dp;
        do_op(2'd2, 1'b0, 32'd200, 32'd0, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'hFFFFFFFF) $display("FAIL div0_quot got=%h want=ffffffff", r); else passed++;
        total++; if (d !== 1'b1) $display("FAIL div0_flag got=%b want=1", d); else passed++;
        total++; if (lat !== 33) $display("FAIL div0_latency got=%0d want=33", lat); else passed++;
        do_op(2'd3, 1'b0, 32'd200, 32'd0, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'd200) $display("FAIL div0_rem got=%0d want=200", r); else passed++;
        total++; if (d !== 1'b1) $display("FAIL div0_rem_flag got=%b want=1", d); else passed++;
        do_op(2'd3, 1'b1, 32'hFFFFFFF9, 32'd0, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'hFFFFFFF9) $display("FAIL div0_rem_signed got=%h want=fffffff9", r); else passed++;
        do_op(2'd0, 1'b0, 32'd3, 32'd4, 1'b0, r, d, lat, bc, dp);
        total++; if (d !== 1'b0) $display("FAIL mul_clears_div0 got=%b want=0", d); else passed++;
        total++; if (r !== 32'd12) $display("FAIL mul_3x4 got=%0d want=12", r); else passed++;
    endtask

    task automatic test_overflow_and_ignore();
        logic [31:0] r; logic d; int lat, bc; logic dp;
        do_op(2'd2, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, d, lat, bc, dp);
        total++; if (r !== 32'h80000000) $display("FAIL ovf_quot_with_ignored_start got=%h want=80000000", r); else passed++;
        total++; if (d !== 1'b0) $display("FAIL ovf_div0 got=%b want=0", d); else passed++;
        total++; if (lat !== 33) $display("FAIL ovf_latency got=%0d want=33", lat); else passed++;
        do_op(2'd3, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, r, d, lat, bc, dp);
        total++; if (r !== 32'h0) $display("FAIL ovf_rem got=%h want=00000000", r); else passed++;
    endtask

    task automatic test_reset_mid_op();
        bit seen_done = 1'b0;
        @(negedge clk1);
        start = 1'b1; op = 2'd2; sgn = 1'b0; a = 32'd1000; b = 32'd3;
        @(posedge clk1); #1;
        start = 1'b0;
        repeat (5) @(posedge clk1);
        #1 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_mid_busy got=%b want=0", busy); else passed++;
        total++; if (result !== 32'd0) $display("FAIL reset_mid_result got=%h want=0", result); else passed++;
        @(negedge clk1); rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk1); #1;
            if (done) seen_done = 1'b1;
        end
        total++; if (seen_done !== 1'b0) $display("FAIL reset_mid_no_done got=%b want=0", seen_done); else passed++;
        $display("reset mid-CALC: busy=%b done_seen=%b", busy, seen_done);
    endtask

    task automatic test_width8();
        logic [7:0] r; int lat;
        do_op8(2'd0, 8'd15, 8'd17, r, lat);
        total++; if (r !== 8'hFF) $display("FAIL w8_mul_15x17 got=%h want=ff", r); else passed++;
        total++; if (lat !== (ET ? 7 : 9)) $display("FAIL w8_mul_latency got=%0d want=%0d", lat, ET ? 7 : 9); else passed++;
        do_op8(2'd0, 8'd15, 8'd1, r, lat);
        total++; if (r !== 8'd15) $display("FAIL w8_mul_b1 got=%h want=0f", r); else passed++;
        total++; if (lat !== (ET ? 3 : 9)) $display("FAIL w8_b1_latency got=%0d want=%0d", lat, ET ? 3 : 9); else passed++;
        do_op8(2'd0, 8'd15, 8'd0, r, lat);
        total++; if (r !== 8'd0) $display("FAIL w8_mul_b0 got=%h want=00", r); else passed++;
        total++; if (lat !== (ET ? 2 : 9)) $display("FAIL w8_b0_latency got=%0d want=%0d", lat, ET ? 2 : 9); else passed++;
        do_op8(2'd2, 8'd200, 8'd7, r, lat);
        total++; if (r !== 8'd28) $display("FAIL w8_div_200_7 got=%0d want=28", r); else passed++;
        total++; if (lat !== 9) $display("FAIL w8_div_latency got=%0d want=9", lat); else passed++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_signed_mul();
        test_divide();
        test_div_zero();
        test_overflow_and_ignore();
        test_reset_mid_op();
        test_width8();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_iter_muldiv.md
Name: mips_iter_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit for the pipe_MIPS32 EX stage. It replaces the single-cycle MUL with a shift-add multiplier and a restoring divider.
- Adds MULH, DIV and REM operations and a signed mode.
- The EX stage stalls on busy and captures result on done.

Parameters:
- WIDTH, 32, operand and result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
- clk1  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- op  input  2  operation, latched with start: 0 MUL (low half), 1 MULH (high half), 2 DIV (quotient), 3 REM (remainder).
- sgn  input  1  1 = operands two's-complement, 0 = unsigned; latched with start.
- a  input  WIDTH  multiplicand / dividend; latched with start.
- b  input  WIDTH  multiplier / divisor; latched with start.
- busy  output  1  high from accept edge until the result edge.
- done  output  1  one-cycle pulse; result valid in the same cycle.
- result  output  WIDTH  operation result; holds until the next done.
- div0  output  1  divisor was zero for the last DIV/REM; updated with done.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, result=0, div0=0; counter and datapath registers cleared.
- States:
  - IDLE -> CALC on start.
  - CALC -> FINISH after WIDTH iterations.
  - FINISH -> IDLE, unconditionally.
- Accept edge E0 (IDLE, start=1):
  - Latch op and sgn.
  - Latch |a| and |b| when sgn=1, else a and b.
  - Record the result sign.
  - Counter=WIDTH; busy=1.
- CALC, edges E1..E_WIDTH, one iteration per edge:
  - Multiply: 2*WIDTH-bit shift-add.
  - Divide: restoring subtract, one quotient bit per edge.
- FINISH, edge E_{WIDTH+1}:
  - Sign correction.
  - Selected half/quotient/remainder written to result.
  - done=1, busy=0, state=IDLE.
- Latency: done is high in the cycle after E_{WIDTH+1}, i.e. WIDTH+1 cycles after the accept edge.
- done lasts exactly one cycle. Back-to-back start is legal in the done cycle and is accepted at the next edge.
- start while busy=1: ignored. Latched operands are unaffected; no queueing.
- Sign rules (sgn=1):
  - Product sign = sign(a) XOR sign(b).
  - Quotient truncates toward zero.
  - Remainder takes the sign of a.
- Multiply wrap: MUL returns the low WIDTH bits of the exact 2*WIDTH product; no overflow flag.
- Divide by zero (b=0, DIV/REM):
  - Quotient = all ones; remainder = a (unmodified, original sign); div0=1.
  - Full latency still applies.
- Signed overflow (sgn=1, a=MIN, b=-1): quotient=MIN, remainder=0, div0=0.
- div0 is cleared at done of any MUL/MULH.
- Reset mid-operation: abort immediately to reset values; no done is produced.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined:
  - In CALC for MUL/MULH, if the remaining unshifted multiplier bits are zero at an edge, skip to FINISH on that edge.
  - Minimum latency is 2 cycles (b=0: FINISH at E1, done after E2).
  - DIV/REM keep fixed latency.
- Undefined: all operations take exactly WIDTH+1 cycles; no early-exit logic is synthesised.

Test Plan:
- WIDTH=32, MUL unsigned, a=5040, b=8 -> done 33 cycles after accept; result=40320; div0=0; busy high for exactly 33 cycles.
- MULH sgn=1, a=32'hFFFFFFFF, b=32'hFFFFFFFF -> result=0; then MUL with the same operands -> result=1.
- DIV then REM, sgn=1, a=-7, b=2 -> quotient 32'hFFFFFFFD (-3); remainder 32'hFFFFFFFF (-1).
- DIV unsigned, a=200, b=0 -> result=32'hFFFFFFFF, div0=1. REM with the same operands -> result=200. A following MUL -> div0=0.
- sgn=1 DIV, a=32'h80000000, b=-1 -> result=32'h80000000. start pulsed mid-operation with different operands -> ignored, result unchanged. rst_n low mid-CALC -> busy=0 immediately; no done.
- WIDTH=8 instance, MUL a=8'd15, b=8'd17 -> result=8'hFF, latency 9. With MULDIV_EARLY_TERM_EN, b=1 -> latency 3; b=0 -> latency 2, result 0.
